vc_val_credit_link_arbiter: RTL and testbench

//  Sender-side scheduler for a val/credit link. Shares one link between NUM_REQS val/rdy requesters.

---
 rtl/vc_val_credit_link_arbiter_pkg.sv | 49 ++++
 rtl/vc_round_robin_arb.sv | 46 ++++
 rtl/vc_val_credit_link_arbiter_chk.sv | 34 +++
 rtl/vc_val_credit_link_arbiter.sv | 109 ++++++++++
 tb/tb_vc_val_credit_link_arbiter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/vc_val_credit_link_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vc_val_credit_link_arbiter_pkg
//   Shared types and helpers for the val/credit link arbiter:
//   - credit_stat_e : coarse state of the sender's credit counter
//   - vc_ptr_w      : width of a round-robin pointer for n requesters
//   - vc_ptr_next   : explicit modulo-n increment of a port index
//   - vc_credit_next: next credit count, saturating at the receiver depth
// ---------------------------------------------------------------------------
package vc_val_credit_link_arbiter_pkg;

  typedef enum logic [1:0] {
    CR_EMPTY = 2'd0,  // no credits, link must stay idle
    CR_AVAIL = 2'd1,  // some but not all receiver entries free
    CR_FULL  = 2'd2   // receiver buffer completely free
  } credit_stat_e;

  // A single requester still needs a 1-bit pointer so no vector collapses to zero width.
  function automatic int unsigned vc_ptr_w(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // Wrap is done by comparison so non-power-of-2 port counts stay correct.
  function automatic int unsigned vc_ptr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

  // take is only ever set when cur is non-zero, so the subtraction cannot wrap.
  function automatic int unsigned vc_credit_next(input int unsigned cur,
                                                 input logic        take,
                                                 input logic        give,
                                                 input int unsigned max);
    int unsigned n;
    n = cur + 32'(give) - 32'(take);
    return (n > max) ? max : n;
  endfunction

  function automatic credit_stat_e vc_credit_stat(input int unsigned cur, input int unsigned max);
    credit_stat_e s;
    if (cur == 32'd0) begin
      s = CR_EMPTY;
    end else if (cur >= max) begin
      s = CR_FULL;
    end else begin
      s = CR_AVAIL;
    end
    return s;
  endfunction

endpackage

// File: rtl/vc_round_robin_arb.sv
// ---------------------------------------------------------------------------
// vc_round_robin_arb
//   Purely combinational round-robin picker. Searches req_i starting at
//   ptr_i and wrapping upward; the first set bit wins.
// Ports:
//   req_i  [NUM_REQS-1:0]  request bits (already qualified by credit/reset)
//   ptr_i  [PTR_W-1:0]     highest-priority port this cycle
//   gnt_o  [NUM_REQS-1:0]  one-hot grant, all zero when no request
//   idx_o  [PTR_W-1:0]     index of the granted port (0 when none)
//   any_o                  a grant was issued
// ---------------------------------------------------------------------------
module vc_round_robin_arb
  import vc_val_credit_link_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned PTR_W    = vc_ptr_w(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req_i,
  input  logic [PTR_W-1:0]    ptr_i,
  output logic [NUM_REQS-1:0] gnt_o,
  output logic [PTR_W-1:0]    idx_o,
  output logic                any_o
);

  // Rotating priority search; once a winner is found later candidates are masked by any_o.
  always_comb begin
    int unsigned      sum;
    logic [PTR_W-1:0] cand;
    logic             hit;
    gnt_o = {NUM_REQS{1'b0}};
    idx_o = {PTR_W{1'b0}};
    any_o = 1'b0;
    sum   = 32'd0;
    cand  = {PTR_W{1'b0}};
    hit   = 1'b0;
    for (int unsigned off = 32'd0; off < NUM_REQS; off++) begin
      sum         = 32'(ptr_i) + off;
      cand        = PTR_W'((sum >= NUM_REQS) ? (sum - NUM_REQS) : sum);
      hit         = !any_o && req_i[cand];
      gnt_o[cand] = gnt_o[cand] | hit;
      idx_o       = hit ? cand : idx_o;
      any_o       = any_o | hit;
    end
  end

endmodule

// File: rtl/vc_val_credit_link_arbiter_chk.sv
// ---------------------------------------------------------------------------
// vc_val_credit_link_arbiter_chk
//   Simulation-only protocol checks for the link arbiter.
// Ports:
//   clk, reset   arbiter clock and synchronous reset
//   cr_stat_i    current credit counter state
//   i_credit     credit return from the receiver
//   rdy_i        grant vector presented to the requesters
// ---------------------------------------------------------------------------
module vc_val_credit_link_arbiter_chk
  import vc_val_credit_link_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4
) (
  input logic                clk,
  input logic                reset,
  input credit_stat_e        cr_stat_i,
  input logic                i_credit,
  input logic [NUM_REQS-1:0] rdy_i
);

  // The receiver cannot free an entry when every entry is already free.
  a_credit_overflow: assert property (@(posedge clk) disable iff (reset)
    !(i_credit && (cr_stat_i == CR_FULL)));

  a_rdy_onehot0: assert property (@(posedge clk) $onehot0(rdy_i));

  a_rdy_no_credit: assert property (@(posedge clk) disable iff (reset)
    (cr_stat_i == CR_EMPTY) |-> (rdy_i == {NUM_REQS{1'b0}}));

  a_rdy_in_reset: assert property (@(posedge clk)
    reset |-> (rdy_i == {NUM_REQS{1'b0}}));

endmodule

// File: rtl/vc_val_credit_link_arbiter.sv
// ---------------------------------------------------------------------------
// vc_val_credit_link_arbiter
//   Sender-side scheduler for a val/credit link. Round-robin arbitrates
//   among NUM_REQS val/rdy requesters, spends one credit per transfer and
//   registers the winning message onto the link one cycle later.
// Ports:
//   clk       clock, all state on posedge
//   reset     synchronous active-high reset (receiver is reset alongside)
//   i_msg     requester messages, port k at [k*MSG_SZ +: MSG_SZ]
//   i_val     requester valids
//   o_rdy     one-hot grant, combinational from i_val and current state
//   o_msg     registered link message, holds when idle
//   o_val     registered link valid, one cycle per transfer
//   i_credit  one receiver entry freed this cycle
// ---------------------------------------------------------------------------
module vc_val_credit_link_arbiter
  import vc_val_credit_link_arbiter_pkg::*;
#(
  parameter int unsigned MSG_SZ      = 32,
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned NUM_CREDITS = 4,
  parameter int unsigned CREDIT_SZ   = 3   // must hold 0..NUM_CREDITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQS*MSG_SZ-1:0]   i_msg,
  input  logic [NUM_REQS-1:0]          i_val,
  output logic [NUM_REQS-1:0]          o_rdy,
  output logic [MSG_SZ-1:0]            o_msg,
  output logic                         o_val,
  input  logic                         i_credit
);

  localparam int unsigned PTR_W = vc_ptr_w(NUM_REQS);

  logic [CREDIT_SZ-1:0] credits_q, credits_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [MSG_SZ-1:0]    msg_q, msg_d;
  logic                 val_q, val_d;

  logic                 credit_ok_s;
  logic [NUM_REQS-1:0]  req_s;
  logic [NUM_REQS-1:0]  gnt_s;
  logic [PTR_W-1:0]     idx_s;
  logic                 grant_s;
  logic [MSG_SZ-1:0]    msg_sel_s;
  credit_stat_e         cr_stat_s;

  // A credit returned this cycle only shows up in credits_q next cycle, so it is not usable now.
  assign credit_ok_s = (credits_q != {CREDIT_SZ{1'b0}}) && !reset;
  assign req_s       = i_val & {NUM_REQS{credit_ok_s}};
  assign o_rdy       = gnt_s;
  assign o_msg       = msg_q;
  assign o_val       = val_q;

  vc_round_robin_arb #(
    .NUM_REQS (NUM_REQS),
    .PTR_W    (PTR_W)
  ) u_arb (
    .req_i (req_s),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s),
    .idx_o (idx_s),
    .any_o (grant_s)
  );

  // Select the winning requester's message by index.
  always_comb begin
    msg_sel_s = {MSG_SZ{1'b0}};
    for (int unsigned k = 32'd0; k < NUM_REQS; k++) begin
      msg_sel_s = (idx_s == PTR_W'(k)) ? i_msg[k*MSG_SZ +: MSG_SZ] : msg_sel_s;
    end
  end

  // Next-state for credits, pointer and link registers.
  always_comb begin
    credits_d = CREDIT_SZ'(vc_credit_next(32'(credits_q), grant_s, i_credit, NUM_CREDITS));
    ptr_d     = grant_s ? PTR_W'(vc_ptr_next(32'(idx_s), NUM_REQS)) : ptr_q;
    val_d     = grant_s;
    msg_d     = grant_s ? msg_sel_s : msg_q;
    cr_stat_s = vc_credit_stat(32'(credits_q), NUM_CREDITS);
  end

  // State registers; reset discards any credit returned in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      credits_q <= CREDIT_SZ'(NUM_CREDITS);
      ptr_q     <= {PTR_W{1'b0}};
      msg_q     <= {MSG_SZ{1'b0}};
      val_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      ptr_q     <= ptr_d;
      msg_q     <= msg_d;
      val_q     <= val_d;
    end
  end

  vc_val_credit_link_arbiter_chk #(
    .NUM_REQS (NUM_REQS)
  ) u_chk (
    .clk       (clk),
    .reset     (reset),
    .cr_stat_i (cr_stat_s),
    .i_credit  (i_credit),
    .rdy_i     (o_rdy)
  );

endmodule

// File: tb/tb_vc_val_credit_link_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vc_val_credit_link_arbiter
//   Directed bench for the link arbiter. The bench plays the receiver: it
//   drives i_credit whenever its sink pops an entry, and keeps an occupancy
//   count of the receiver buffer to confirm it never exceeds its depth.
// ---------------------------------------------------------------------------
module tb_vc_val_credit_link_arbiter;

  logic         clk;
  logic         reset;
  logic [127:0] i_msg;
  logic [3:0]   i_val;
  logic [3:0]   o_rdy;
  logic [31:0]  o_msg;
  logic         o_val;
  logic         i_credit;

  int n_cmp = 0;
  int n_err = 0;
  int stp   = 0;
  int rx_cnt;

  localparam logic [23:0] TA = 24'hA0A0A0;
  localparam logic [23:0] TB = 24'hB1B1B1;
  localparam logic [23:0] TC = 24'hC2C2C2;
  localparam logic [23:0] TD = 24'hD3D3D3;

  vc_val_credit_link_arbiter #(
    .MSG_SZ      (32),
    .NUM_REQS    (4),
    .NUM_CREDITS (4),
    .CREDIT_SZ   (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_msg    (i_msg),
    .i_val    (i_val),
    .o_rdy    (o_rdy),
    .o_msg    (o_msg),
    .o_val    (o_val),
    .i_credit (i_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiver buffer occupancy: arrivals on o_val, departures signalled by i_credit.
  always @(posedge clk) begin
    if (reset) rx_cnt <= 0;
    else       rx_cnt <= rx_cnt + int'(o_val) - int'(i_credit);
  end

  function automatic logic [31:0] mk(input logic [23:0] t, input int k);
    return {t, 8'(k)};
  endfunction

  task automatic set_tag(input logic [23:0] t);
    for (int k = 0; k < 4; k++) i_msg[k*32 +: 32] = mk(t, k);
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then advance past the next edge.
  task automatic step(input logic rst, input logic [3:0] v, input logic cr,
                      input logic [3:0] erdy, input logic eval, input logic [31:0] emsg);
    stp++;
    reset    = rst;
    i_val    = v;
    i_credit = cr;
    #2;
    chk($sformatf("s%0d_rdy", stp), {28'd0, o_rdy}, {28'd0, erdy});
    chk($sformatf("s%0d_val", stp), {31'd0, o_val}, {31'd0, eval});
    chk($sformatf("s%0d_msg", stp), o_msg, emsg);
    chk($sformatf("s%0d_rx_bound", stp), {31'd0, (rx_cnt <= 4)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    i_val    = 4'b1111;
    i_credit = 1'b0;
    set_tag(TA);
    @(posedge clk);
    #1;

    // 1: reset held with all ports valid, first grant to port 0 afterwards
    step(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 32'd0);
    step(1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 32'd0);
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 32'd0);

    // 2: fairness with sink always returning a credit
    step(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, mk(TA, 0));
    step(1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, mk(TA, 1));
    step(1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, mk(TA, 2));
    step(1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, mk(TA, 3));
    step(1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, mk(TA, 0));
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, mk(TA, 1));
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, mk(TA, 1));

    // 3: credit exhaustion on port 2 with sink stalled, then resume
    set_tag(TB);
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, mk(TA, 1));
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, mk(TB, 2));
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, mk(TB, 2));
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, mk(TB, 2));
    step(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, mk(TB, 2));
    step(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, mk(TB, 2));
    step(1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, mk(TB, 2));
    // 4: credits==1, grant and return together keep the count at 1
    step(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, mk(TB, 2));
    step(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, mk(TB, 2));
    step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, mk(TB, 2));
    step(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b1, mk(TB, 2));

    // drain the receiver back to full credit
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, mk(TB, 2));
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, mk(TB, 2));
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, mk(TB, 2));
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, mk(TB, 2));

    // 5: move ptr to 1, then i_val=1001 alternates 3,0,3
    set_tag(TC);
    step(1'b0, 4'b0001, 1'b0, 4'b0001, 1'b0, mk(TB, 2));
    step(1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, mk(TC, 0));
    step(1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, mk(TC, 3));
    step(1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, mk(TC, 0));
    step(1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, mk(TC, 3));

    // 6: reset with three messages outstanding, then four clean transfers
    set_tag(TD);
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, mk(TC, 3));
    step(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, mk(TD, 0));
    step(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, mk(TD, 1));
    step(1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, mk(TD, 2));
    step(1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0, 32'd0);
    step(1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, mk(TD, 0));
    step(1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, mk(TD, 1));
    step(1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, mk(TD, 2));
    step(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, mk(TD, 3));
    step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, mk(TD, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
